// File: rtl/uart_mng_pkg.sv
// uart_mng_pkg: shared command encodings, status bit positions and FSM states
package uart_mng_pkg;
  localparam logic [1:0] CMD_NOP_CLR    = 2'b00;
  localparam logic [1:0] CMD_TX_LO      = 2'b01;
  localparam logic [1:0] CMD_TX_HI_SEND = 2'b10;
  localparam logic [1:0] CMD_RX_READ    = 2'b11;
  localparam int ACK     = 7;
  localparam int TX_BUSY = 6;
  localparam int RX_NE   = 5;
  localparam int RX_OVR  = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_mng_if.sv
// uart_mng_if: PIO command/status byte pair between NIOS PIO and bridge
interface uart_mng_if;
  logic [7:0] pio_out;
  logic [7:0] pio_in;
  modport master(output pio_out, input pio_in);
  modport slave(input pio_out, output pio_in);
endinterface

// File: rtl/uart_mng_rx.sv
// uart_mng_rx: synchronised 8N1 receiver producing a one-cycle byte-valid pulse
module uart_mng_rx
  import uart_mng_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid
);
  localparam int CW = $clog2(DIV);
  logic s1, s2, s3;
  uart_state_e st;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic last;
  assign last = cnt == CW'(DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      {s3, s2, s1} <= 3'b111;
      st <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      data <= '0;
      valid <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, uart_rx};
      valid <= 1'b0;
      cnt <= cnt + CW'(1);
      case (st)
        IDLE: begin
          cnt <= '0;
          if (s3 && !s2) st <= START;
        end
        START: if (cnt == CW'(DIV / 2 - 1)) begin
          cnt <= '0;
          bit_cnt <= '0;
          st <= s2 ? IDLE : DATA;
        end
        DATA: if (last) begin
          cnt <= '0;
          data <= {s2, data[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) st <= STOP;
        end
        STOP: if (last) begin
          cnt <= '0;
          valid <= s2;
          st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_mng_bridge.sv
// uart_mng_bridge: PIO toggle-handshake command decoder with 8N1 TX, RX and RX FIFO
module uart_mng_bridge
  import uart_mng_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int RX_DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  uart_mng_if.slave pio,
  input  logic  uart_rx,
  output logic  uart_tx
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(RX_DEPTH);
  logic req_q, ack_q, ovr_q, ne_q;
  logic [3:0] nib_q;
  logic [7:0] shadow, txd;
  uart_state_e tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] mem [RX_DEPTH];
  logic [AW:0] wr, rd;
  logic [7:0] rx_data, head;
  logic rx_valid;
  logic [1:0] cmd;
  logic [3:0] arg;
  logic exec, send, empty, full, pop, push, tx_last, unused_rsv;
  assign cmd = pio.pio_out[6:5];
  assign arg = pio.pio_out[3:0];
  assign unused_rsv = pio.pio_out[4];
  assign exec = pio.pio_out[7] != req_q;
  assign send = exec && cmd == CMD_TX_HI_SEND && tx_st == IDLE;
  assign empty = wr == rd;
  assign full = wr[AW] != rd[AW] && wr[AW-1:0] == rd[AW-1:0];
  assign pop = exec && cmd == CMD_RX_READ && arg[0] && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push = rx_valid && (!full || pop);
  assign head = mem[rd[AW-1:0]];
  assign tx_last = tx_cnt == CW'(DIV - 1);
  assign pio.pio_in = {ack_q, tx_st != IDLE, ne_q, ovr_q, nib_q};

  uart_mng_rx #(.DIV(DIV)) u_rx (
    .clk(clk),
    .reset(reset),
    .uart_rx(uart_rx),
    .data(rx_data),
    .valid(rx_valid)
  );

  always_ff @(posedge clk) if (push) mem[wr[AW-1:0]] <= rx_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= 1'b0;
      ack_q <= 1'b0;
      ovr_q <= 1'b0;
      ne_q <= 1'b0;
      nib_q <= '0;
      shadow <= '0;
      wr <= '0;
      rd <= '0;
    end else begin
      req_q <= pio.pio_out[7];
      ne_q <= !empty;
      if (exec) ack_q <= pio.pio_out[7];
      if (exec && cmd == CMD_TX_LO) shadow[3:0] <= arg;
      if (exec && cmd == CMD_TX_HI_SEND) shadow[7:4] <= arg;
      if (exec && cmd == CMD_RX_READ) nib_q <= empty ? 4'h0 : arg[0] ? head[7:4] : head[3:0];
      if (exec && cmd == CMD_NOP_CLR && arg[0]) ovr_q <= 1'b0;
      if (rx_valid && !push) ovr_q <= 1'b1;
      if (push) wr <= wr + (AW+1)'(1);
      if (pop) rd <= rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st <= IDLE;
      uart_tx <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      txd <= '0;
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
      case (tx_st)
        IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          uart_tx <= !send;
          if (send) begin
            tx_st <= START;
            txd <= {arg, shadow[3:0]};
          end
        end
        START: if (tx_last) begin
          tx_cnt <= '0;
          tx_st <= DATA;
          uart_tx <= txd[0];
        end
        DATA: if (tx_last) begin
          tx_cnt <= '0;
          tx_bit <= tx_bit + 3'd1;
          txd <= {1'b0, txd[7:1]};
          uart_tx <= tx_bit == 3'd7 ? 1'b1 : txd[1];
          if (tx_bit == 3'd7) tx_st <= STOP;
        end
        STOP: if (tx_last) begin
          tx_cnt <= '0;
          tx_st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_mng_bridge.md
Name: uart_mng_bridge

Overview:
Byte-level UART engine that sits directly behind the 8-bit uart_mng PIO. It consumes the PIO's out_port as a toggle-handshaked command byte and drives the PIO's in_port with status and RX data. It contains an 8N1 transmitter, an 8N1 receiver and a small RX FIFO, so the NIOS II can run a serial link using only PIO reads and writes.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; DIV = CLK_FREQ/BAUD (integer, must be >= 4)
RX_DEPTH, 4, RX FIFO depth in bytes (power of 2, >= 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pio_out  in  8  command byte from PIO out_port: [7]=req toggle, [6:5]=cmd, [4]=unused, [3:0]=arg nibble
pio_in  out  8  to PIO in_port: [7]=ack toggle, [6]=tx_busy, [5]=rx_nonempty, [4]=rx_overrun, [3:0]=data nibble
uart_rx  in  1  serial input, asynchronous, idle high
uart_tx  out  1  serial output, idle high

Behaviour:
- Reset: pio_in=8'h00, uart_tx=1, TX and RX idle, FIFO empty, overrun=0, TX shadow byte=0. Reset mid-frame aborts immediately; uart_tx is high the cycle after reset is asserted.
- Handshake: req_q registers pio_out[7]. A command executes in any cycle where pio_out[7] != req_q. In the next cycle ack (pio_in[7]) equals the new req, and status/nibble reflect the command. One command per toggle; a toggle while a previous command is still being acked is impossible because execution takes one cycle.
- cmd 00: if arg[0]=1, clear overrun; otherwise no operation. Ack always.
- cmd 01: TX shadow[3:0] <= arg.
- cmd 10: TX shadow[7:4] <= arg. If TX is idle, start transmitting {arg, shadow[3:0]}. If TX is busy, the shadow is updated, no send occurs, and ack still toggles. Software polls tx_busy.
- cmd 11: if arg[0]=0, nibble <= FIFO head[3:0], no pop. If arg[0]=1, nibble <= head[7:4] and pop. If the FIFO is empty, nibble <= 0 and no pop.
- TX FSM (IDLE, START, DATA, STOP): bit counter 0..7, baud counter 0..DIV-1. Start bit begins the cycle after the cmd 10 execute. Frame order: start(0), data bits LSB first, stop(1), each DIV cycles. tx_busy=1 from the execute cycle+1 through the last stop-bit cycle, so a frame is 10*DIV cycles. Back-to-back sends are allowed the cycle tx_busy falls.
- RX: uart_rx passes through a 2-FF synchroniser. RX FSM (IDLE, START, DATA, STOP):
  - A falling edge in IDLE moves to START and waits DIV/2 cycles.
  - If the line is still 0, the FSM proceeds. If it is 1, the event is a glitch and the FSM returns to IDLE.
  - Eight samples are taken DIV apart, LSB first, then the stop sample DIV later.
  - Stop=1: push the byte. If the FIFO is full, drop the byte and set overrun (sticky).
  - Stop=0: framing error; discard the byte with no flag.
  - After the stop sample the FSM returns to IDLE and can detect a new start edge immediately.
- FIFO: circular with log2(RX_DEPTH)+1-bit pointers; full when pointers differ only in the MSB. A push and a pop in the same cycle are both honoured, including when the FIFO is full, in which case the pop frees space first and no overrun is raised.
- rx_nonempty and rx_overrun are registered and update one cycle after the FIFO or flag change.

Decomposition:
- Package uart_mng_pkg holds:
  - cmd encodings: CMD_NOP_CLR=2'b00, CMD_TX_LO=2'b01, CMD_TX_HI_SEND=2'b10, CMD_RX_READ=2'b11
  - pio_in bit indices: ACK=7, TX_BUSY=6, RX_NE=5, RX_OVR=4
  - TX/RX state enum
- One sub-module, uart_mng_rx, contains the synchroniser, the RX FSM and the byte-valid pulse. The TX FSM, FIFO and command decode stay in the top level.

Test Plan (CLK_FREQ=1000, BAUD=100, so DIV=10):
- Reset, then idle 20 cycles -> pio_in=8'h00, uart_tx=1 throughout.
- Send cmd01 arg 5, then cmd10 arg A, each with a toggled req -> ack follows each toggle 1 cycle later; uart_tx carries 0,1,0,1,0,0,1,0,1,1 at 10 cycles per bit (0xA5 LSB first); tx_busy high for exactly 100 cycles.
- Issue cmd10 arg 3 while busy -> ack toggles, current frame unchanged, no second frame starts.
- Drive 0x3C serially on uart_rx -> rx_nonempty=1. cmd11 arg0 -> nibble=C. cmd11 arg1 -> nibble=3, rx_nonempty returns to 0.
- Receive 5 bytes with RX_DEPTH=4 and no reads -> rx_overrun=1 and the first 4 bytes read back in order. Then cmd00 arg1 -> overrun=0.
- Apply a 3-cycle low glitch, then a frame with stop=0 -> nothing pushed, rx_nonempty stays 0. Assert reset mid-TX-frame -> uart_tx=1 the next cycle.
